enable_sequencer: RTL and testbench

ENABLE_SEQUENCER -- requirements
Module: enable_sequencer

---
 rtl/enable_sequencer_pkg.sv | 14 +
 rtl/enable_sequencer_seq_timer.sv | 39 +++
 rtl/enable_sequencer.sv | 135 +++++++++++++
 tb/tb_enable_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/enable_sequencer_pkg.sv
// Shared state encoding and default widths for the enable sequencer.
package enable_sequencer_pkg;

    localparam int unsigned DEF_LEN_W = 4;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/enable_sequencer_seq_timer.sv
// Loadable down-counter timing one RUN or GAP phase; zero marks the last cycle.
module seq_timer
    import enable_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [LEN_W-1:0] load_val,
    output logic             zero
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;

    // Next count: load has priority over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/enable_sequencer.sv
// Burst/gap enable sequencer: emits burst_len enable cycles separated by
// gap_len idle cycles, num_bursts times (0 = until stop).
module enable_sequencer
    import enable_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] burst_len,
    input  logic [LEN_W-1:0] gap_len,
    input  logic [CNT_W-1:0] num_bursts,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] burst_count
);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] burst_len_q, burst_len_d;
    logic [LEN_W-1:0] gap_len_q, gap_len_d;
    logic [CNT_W-1:0] num_bursts_q, num_bursts_d;
    logic [CNT_W-1:0] burst_count_q, burst_count_d;
    logic [CNT_W-1:0] count_inc;

    logic             tmr_load;
    logic             tmr_dec;
    logic [LEN_W-1:0] tmr_val;
    logic             tmr_zero;

    seq_timer #(
        .LEN_W(LEN_W)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .load_val(tmr_val),
        .zero    (tmr_zero)
    );

    assign count_inc = burst_count_q + 1'b1;

    // Next-state, latched fields and timer control.
    // The timer is loaded with length-1 so that zero flags the final cycle of a phase.
    always_comb begin
        state_d       = state_q;
        burst_len_d   = burst_len_q;
        gap_len_d     = gap_len_q;
        num_bursts_d  = num_bursts_q;
        burst_count_d = burst_count_q;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        tmr_val       = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    burst_len_d   = burst_len;
                    gap_len_d     = gap_len;
                    num_bursts_d  = num_bursts;
                    burst_count_d = '0;
                    if (burst_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RUN;
                        tmr_load = 1'b1;
                        tmr_val  = burst_len - 1'b1;
                    end
                end
            end
            RUN: begin
                if (tmr_zero) begin
                    burst_count_d = count_inc;
                    if (stop || ((num_bursts_q != '0) && (count_inc == num_bursts_q))) begin
                        state_d = DONE;
                    end else if (gap_len_q == '0) begin
                        tmr_load = 1'b1;
                        tmr_val  = burst_len_q - 1'b1;
                    end else begin
                        state_d  = GAP;
                        tmr_load = 1'b1;
                        tmr_val  = gap_len_q - 1'b1;
                    end
                end else if (stop) begin
                    state_d = DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = DONE;
                end else if (tmr_zero) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                    tmr_val  = burst_len_q - 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-field registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            burst_len_q   <= '0;
            gap_len_q     <= '0;
            num_bursts_q  <= '0;
            burst_count_q <= '0;
        end else begin
            state_q       <= state_d;
            burst_len_q   <= burst_len_d;
            gap_len_q     <= gap_len_d;
            num_bursts_q  <= num_bursts_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign enable      = (state_q == RUN);
    assign busy        = (state_q == RUN) || (state_q == GAP);
    assign done        = (state_q == DONE);
    assign burst_count = burst_count_q;

endmodule

// File: tb/tb_enable_sequencer.sv
// Self-checking bench for enable_sequencer against a waveform-level model.
module tb_enable_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [3:0] burst_len;
    logic [3:0] gap_len;
    logic [7:0] num_bursts;
    logic       enable;
    logic       busy;
    logic       done;
    logic [7:0] burst_count;

    int checks = 0;
    int errors = 0;

    // Downstream 4-bit counter driven by the sequencer enable.
    logic       ds_clr;
    logic [3:0] ds_cnt;

    enable_sequencer #(
        .LEN_W(4),
        .CNT_W(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .burst_len  (burst_len),
        .gap_len    (gap_len),
        .num_bursts (num_bursts),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .burst_count(burst_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ds_clr) ds_cnt <= 4'd0;
        else if (enable) ds_cnt <= ds_cnt + 4'd1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Bursts fully completed before cycle t (cycle 0 = first cycle after start edge).
    function automatic int completed(input int l, input int g, input int t);
        if (l == 0 || t < l) return 0;
        return ((t - l) / (l + g) + 1) % 256;
    endfunction

    // Run one sequence; stop_at < 0 means no stop. Mid-run inputs are scrambled.
    task automatic run_seq(input int l, input int g, input int n, input int stop_at);
        int total;
        int last;
        int exp_ds;
        logic exp_en;
        total = (n == 0) ? -1 : ((l == 0) ? 0 : n * l + (n - 1) * g);
        if (l == 0) last = 0;
        else if (stop_at >= 0 && (total < 0 || stop_at < total)) last = stop_at + 1;
        else last = total;
        exp_ds     = 0;
        burst_len  = 4'(l);
        gap_len    = 4'(g);
        num_bursts = 8'(n);
        start      = 1'b1;
        stop       = 1'($urandom);
        ds_clr     = 1'b1;
        step();
        ds_clr = 1'b0;
        for (int t = 0; t < last; t++) begin
            exp_en = ((t % (l + g)) < l);
            if (exp_en) exp_ds++;
            chk("run_enable", 32'(enable), 32'(exp_en));
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_count", 32'(burst_count), 32'(completed(l, g, t)));
            stop       = (t == stop_at);
            start      = 1'($urandom);
            burst_len  = 4'($urandom);
            gap_len    = 4'($urandom);
            num_bursts = 8'($urandom);
            step();
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_enable", 32'(enable), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_count", 32'(burst_count), 32'(completed(l, g, last)));
        chk("ds_counter", 32'(ds_cnt), 32'(exp_ds % 16));
        start = 1'b0;
        stop  = 1'b0;
        step();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_enable", 32'(enable), 32'd0);
        chk("idle_count", 32'(burst_count), 32'(completed(l, g, last)));
    endtask

    initial begin
        int l, g, n, s, total;
        reset      = 1'b1;
        start      = 1'b1;
        stop       = 1'b1;
        burst_len  = 4'd3;
        gap_len    = 4'd2;
        num_bursts = 8'd2;
        ds_clr     = 1'b1;
        step();
        step();
        chk("rst_enable", 32'(enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(burst_count), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b1;
        step();
        chk("idle_stop_ignored", 32'(busy | done), 32'd0);
        stop = 1'b0;

        run_seq(3, 2, 2, -1);    // 1,1,1,0,0,1,1,1 then done, downstream reads 6
        run_seq(4, 0, 3, -1);    // 12 back-to-back enable cycles
        run_seq(0, 3, 1, -1);    // zero-length burst goes straight to done
        run_seq(5, 1, 0, 8);     // stop on 3rd cycle of 2nd burst
        run_seq(3, 1, 2, 2);     // stop on final RUN cycle still counts the burst
        run_seq(3, 2, 0, 3);     // stop in GAP
        run_seq(1, 0, 0, 259);   // unlimited: burst_count wraps 255 -> 0

        for (int i = 0; i < 10; i++) begin
            l = $urandom_range(0, 6);
            g = $urandom_range(0, 3);
            n = $urandom_range(0, 3);
            total = n * l + (n - 1) * g;
            if (n == 0) s = $urandom_range(0, 30);
            else if ($urandom_range(0, 1) == 1) s = $urandom_range(0, (total > 0 ? total : 0) + 2);
            else s = -1;
            run_seq(l, g, n, s);
        end

        // Reset during GAP with start held high.
        burst_len  = 4'd3;
        gap_len    = 4'd4;
        num_bursts = 8'd0;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 4; t++) step();
        chk("gap_reached", 32'({busy, enable}), 32'b10);
        reset = 1'b1;
        start = 1'b1;
        step();
        chk("gaprst_enable", 32'(enable), 32'd0);
        chk("gaprst_busy", 32'(busy), 32'd0);
        chk("gaprst_done", 32'(done), 32'd0);
        chk("gaprst_count", 32'(burst_count), 32'd0);
        step();
        chk("gaprst_nodone", 32'(done), 32'd0);
        reset = 1'b0;
        step();
        chk("restart_enable", 32'(enable), 32'd1);
        chk("restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        stop  = 1'b1;
        step();
        chk("restart_stop_done", 32'(done), 32'd1);
        chk("restart_stop_count", 32'(burst_count), 32'd0);
        stop = 1'b0;
        step();

        // Reset mid-RUN drops enable at the same edge, no done pulse.
        burst_len = 4'd5;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("runrst_pre_enable", 32'(enable), 32'd1);
        reset = 1'b1;
        step();
        chk("runrst_enable", 32'(enable), 32'd0);
        chk("runrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        step();
        chk("runrst_after_done", 32'(done), 32'd0);
        chk("runrst_after_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
